// File: rtl/control_unit.sv
// control_unit
// Multi-cycle instruction sequencer for the 10-bit processor. It latches an
// instruction word on a rising edge of Exec, then walks through time steps
// T1..T3. In each step it drives the ALU and register-file strobes so that
// exactly one source owns the shared 10-bit bus. All state changes on the
// falling edge of CLKb.
//
// Ports:
//   CLKb  - system clock, active on its negative edge
//   Rstb  - asynchronous active-low reset
//   Exec  - start request (rising edge starts an instruction)
//   INSTR - instruction word: [9:6] opcode, [5:4] Rx, [3:2] Ry, [1:0] unused
//   FN    - ALU function select (opcode while busy, 0 when idle)
//   Ain   - ALU operand-latch strobe
//   Gin   - ALU result-latch strobe
//   Gout  - ALU result onto bus
//   Rin   - one-hot register load enable
//   Rout  - one-hot register bus-drive enable
//   ExtIn - external data onto bus
//   Busy  - instruction in progress (T1..T3)
//   Done  - final step of the current instruction
//   Err   - last accepted opcode was illegal (sticky until next start)
//   Tstep - current time step (0 = T0 .. 3 = T3)
module control_unit (
   input  logic       CLKb,
   input  logic       Rstb,
   input  logic       Exec,
   input  logic [9:0] INSTR,
   output logic [3:0] FN,
   output logic       Ain,
   output logic       Gin,
   output logic       Gout,
   output logic [3:0] Rin,
   output logic [3:0] Rout,
   output logic       ExtIn,
   output logic       Busy,
   output logic       Done,
   output logic       Err,
   output logic [1:0] Tstep
);

   localparam logic [1:0] T0 = 2'd0;
   localparam logic [1:0] T1 = 2'd1;
   localparam logic [1:0] T2 = 2'd2;
   localparam logic [1:0] T3 = 2'd3;

   logic [1:0] state_q, state_d;
   logic [9:0] ir_q, ir_d;
   logic       exec_dly_q, exec_dly_d;
   logic       err_q, err_d;

   logic [3:0] opcode;
   logic [3:0] rx_oh;
   logic [3:0] ry_oh;
   logic       is_load, is_mov, is_bin, is_un, is_ill;
   logic       start;

   // Instruction class decode from the latched opcode
   always_comb begin
      opcode  = ir_q[9:6];
      rx_oh   = 4'b0001 << ir_q[5:4];
      ry_oh   = 4'b0001 << ir_q[3:2];
      is_load = 1'b0;
      is_mov  = 1'b0;
      is_bin  = 1'b0;
      is_un   = 1'b0;
      is_ill  = 1'b0;
      case (opcode)
         4'b0000:                                   is_load = 1'b1;
         4'b0001:                                   is_mov  = 1'b1;
         4'b0010, 4'b0011, 4'b0110, 4'b0111, 4'b1000: is_bin  = 1'b1;
         4'b0100, 4'b0101, 4'b1001, 4'b1010, 4'b1011: is_un   = 1'b1;
         default:                                   is_ill  = 1'b1;
      endcase
   end

   // Moore strobe decode; every strobe is zero in T0 so the bus floats idle
   always_comb begin
      FN    = 4'b0000;
      Ain   = 1'b0;
      Gin   = 1'b0;
      Gout  = 1'b0;
      Rin   = 4'b0000;
      Rout  = 4'b0000;
      ExtIn = 1'b0;
      Done  = 1'b0;
      if (state_q != T0) begin
         FN = opcode;
      end
      case (state_q)
         T1: begin
            if (is_load) begin
               ExtIn = 1'b1;
               Rin   = rx_oh;
               Done  = 1'b1;
            end else if (is_mov) begin
               Rout = ry_oh;
               Rin  = rx_oh;
               Done = 1'b1;
            end else if (is_bin) begin
               Rout = ry_oh;
               Ain  = 1'b1;
            end else if (is_un) begin
               Rout = rx_oh;
               Gin  = 1'b1;
            end else begin
               Done = 1'b1;
            end
         end
         T2: begin
            if (is_bin) begin
               Rout = rx_oh;
               Gin  = 1'b1;
            end else if (is_un) begin
               Gout = 1'b1;
               Rin  = rx_oh;
               Done = 1'b1;
            end
         end
         T3: begin
            if (is_bin) begin
               Gout = 1'b1;
               Rin  = rx_oh;
               Done = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   // Sequencing: a fresh Exec edge only counts while idle, and the step
   // after a Done always returns to T0. T3 wraps to T0 as a safety net.
   always_comb begin
      start      = (state_q == T0) && Exec && !exec_dly_q;
      exec_dly_d = Exec;
      ir_d       = ir_q;
      err_d      = err_q;
      state_d    = state_q;
      if (state_q == T0) begin
         if (start) begin
            state_d = T1;
            ir_d    = INSTR;
            err_d   = 1'b0;
         end
      end else if (Done || state_q == T3) begin
         state_d = T0;
      end else begin
         state_d = state_q + 2'd1;
      end
      if (state_q == T1 && is_ill) begin
         err_d = 1'b1;
      end
   end

   always_ff @(negedge CLKb or negedge Rstb) begin
      if (!Rstb) begin
         state_q    <= T0;
         ir_q       <= 10'd0;
         exec_dly_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ir_q       <= ir_d;
         exec_dly_q <= exec_dly_d;
         err_q      <= err_d;
      end
   end

   assign Busy  = (state_q != T0);
   assign Err   = err_q;
   assign Tstep = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit. A small datapath model (four registers, ALU
// operand/result latches, external data) is driven by the DUT strobes on each
// falling clock edge. An independent instruction-level model predicts the
// register file after every instruction.
module tb_control_unit;

   logic       CLKb = 1'b0;
   logic       Rstb;
   logic       Exec;
   logic [9:0] INSTR;
   logic [3:0] FN;
   logic       Ain, Gin, Gout, ExtIn, Busy, Done, Err;
   logic [3:0] Rin, Rout;
   logic [1:0] Tstep;

   int testsRun    = 0;
   int testsFailed = 0;

   logic [9:0]  regs[4];
   logic [9:0]  refRegs[4];
   logic [9:0]  presetVal[4];
   int          presetSeq  = 0;
   int          presetSeen = 0;
   logic [9:0]  aLatch = '0;
   logic [9:0]  gLatch = '0;
   logic [9:0]  extData = '0;
   logic [9:0]  bus;
   logic [16:0] trace[8];
   int          nCyc;
   int          doneCount;

   typedef struct {
      logic [9:0]  instr;
      logic [16:0] t1Out;
      int          latency;
      logic        errAfter;
   } vec_t;

   vec_t vecs[10];

   always #5 CLKb = ~CLKb;

   control_unit dut (
      .CLKb (CLKb),
      .Rstb (Rstb),
      .Exec (Exec),
      .INSTR(INSTR),
      .FN   (FN),
      .Ain  (Ain),
      .Gin  (Gin),
      .Gout (Gout),
      .Rin  (Rin),
      .Rout (Rout),
      .ExtIn(ExtIn),
      .Busy (Busy),
      .Done (Done),
      .Err  (Err),
      .Tstep(Tstep)
   );

   // Packed strobe view: [16:13] FN, [12] Ain, [11] Gin, [10] Gout,
   // [9] ExtIn, [8] Done, [7:4] Rin, [3:0] Rout
   function automatic logic [16:0] packOut();
      return {FN, Ain, Gin, Gout, ExtIn, Done, Rin, Rout};
   endfunction

   function automatic logic [9:0] aluModel(input logic [3:0] fn, input logic [9:0] a, input logic [9:0] b);
      case (fn)
         4'b0010: return b + a;
         4'b0011: return b - a;
         4'b0110: return b & a;
         4'b0111: return b | a;
         4'b1000: return b ^ a;
         4'b0100: return -b;
         4'b0101: return ~b;
         4'b1001: return {b[8:0], 1'b0};
         4'b1010: return {1'b0, b[9:1]};
         4'b1011: return {b[9], b[9:1]};
         default: return 10'd0;
      endcase
   endfunction

   function automatic int expLatency(input logic [3:0] op);
      case (op)
         4'b0010, 4'b0011, 4'b0110, 4'b0111, 4'b1000: return 3;
         4'b0100, 4'b0101, 4'b1001, 4'b1010, 4'b1011: return 2;
         default: return 1;
      endcase
   endfunction

   // Datapath model: the DUT strobes valid at the falling edge decide who
   // drives the bus and who latches it
   always @(negedge CLKb) begin
      if (presetSeen != presetSeq) begin
         for (int i = 0; i < 4; i++) regs[i] = presetVal[i];
         presetSeen = presetSeq;
      end
      bus = '0;
      if (ExtIn) bus = extData;
      else if (Gout) bus = gLatch;
      else for (int i = 0; i < 4; i++) if (Rout[i]) bus = regs[i];
      if (Ain) aLatch = bus;
      if (Gin) gLatch = aluModel(FN, aLatch, bus);
      for (int i = 0; i < 4; i++) if (Rin[i]) regs[i] = bus;
   end

   task automatic setRegs(input logic [9:0] r0, input logic [9:0] r1, input logic [9:0] r2, input logic [9:0] r3);
      presetVal[0] = r0; presetVal[1] = r1; presetVal[2] = r2; presetVal[3] = r3;
      refRegs[0]   = r0; refRegs[1]   = r1; refRegs[2]   = r2; refRegs[3]   = r3;
      presetSeq++;
   endtask

   task automatic refStep(input logic [9:0] instr);
      logic [3:0] op;
      logic [9:0] x, y;
      op = instr[9:6];
      x  = refRegs[instr[5:4]];
      y  = refRegs[instr[3:2]];
      case (op)
         4'b0000: refRegs[instr[5:4]] = extData;
         4'b0001: refRegs[instr[5:4]] = y;
         4'b0010: refRegs[instr[5:4]] = x + y;
         4'b0011: refRegs[instr[5:4]] = x - y;
         4'b0110: refRegs[instr[5:4]] = x & y;
         4'b0111: refRegs[instr[5:4]] = x | y;
         4'b1000: refRegs[instr[5:4]] = x ^ y;
         4'b0100: refRegs[instr[5:4]] = 10'd0 - x;
         4'b0101: refRegs[instr[5:4]] = ~x;
         4'b1001: refRegs[instr[5:4]] = x << 1;
         4'b1010: refRegs[instr[5:4]] = x >> 1;
         4'b1011: refRegs[instr[5:4]] = {x[9], x[9:1]};
         default: begin
         end
      endcase
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Start one instruction from idle and trace every busy cycle. Entered and
   // left at #1 after a falling edge with Exec low at the previous edge.
   task automatic applyStimulus(input logic [9:0] instr);
      refStep(instr);
      INSTR     = instr;
      Exec      = 1'b1;
      nCyc      = 0;
      doneCount = 0;
      @(negedge CLKb); #1;
      Exec = 1'b0;
      while (Tstep != 2'd0 && nCyc < 8) begin
         trace[nCyc] = packOut();
         checkOutput("busExclusive", 64'($countones({ExtIn, Gout, Rout}) <= 1), 64'd1);
         checkOutput("rinOneHot", 64'($countones(Rin) <= 1), 64'd1);
         checkOutput("busyInStep", 64'(Busy), 64'd1);
         checkOutput("doneThenIdle", 64'(doneCount), 64'd0);
         if (Done) doneCount++;
         nCyc++;
         @(negedge CLKb); #1;
      end
      if (nCyc >= 8) begin
         checkOutput("timeout", 64'(nCyc), 64'd0);
      end
      checkOutput("doneCount", 64'(doneCount), 64'd1);
      checkOutput("idleBusy", 64'(Busy), 64'd0);
   endtask

   initial begin
      Rstb  = 1'b0;
      Exec  = 1'b0;
      INSTR = 10'd0;
      setRegs(10'd0, 10'd0, 10'd0, 10'd0);
      #12;
      checkOutput("resetOutputs", 64'({packOut(), Busy, Err, Tstep}), 64'd0);
      @(posedge CLKb);
      Rstb = 1'b1;
      @(negedge CLKb); #1;
      checkOutput("idleAfterRelease", 64'({Busy, Tstep}), 64'd0);

      // Directed vector table: strobes in T1, latency and Err afterwards
      vecs[0] = '{10'b0000_11_00_00, {4'b0000, 5'b00011, 4'b1000, 4'b0000}, 1, 1'b0};
      vecs[1] = '{10'b0001_00_10_00, {4'b0001, 5'b00001, 4'b0001, 4'b0100}, 1, 1'b0};
      vecs[2] = '{10'b0001_01_01_00, {4'b0001, 5'b00001, 4'b0010, 4'b0010}, 1, 1'b0};
      vecs[3] = '{10'b0010_01_10_00, {4'b0010, 5'b10000, 4'b0000, 4'b0100}, 3, 1'b0};
      vecs[4] = '{10'b0011_11_00_00, {4'b0011, 5'b10000, 4'b0000, 4'b0001}, 3, 1'b0};
      vecs[5] = '{10'b1000_10_01_00, {4'b1000, 5'b10000, 4'b0000, 4'b0010}, 3, 1'b0};
      vecs[6] = '{10'b0100_10_00_00, {4'b0100, 5'b01000, 4'b0000, 4'b0100}, 2, 1'b0};
      vecs[7] = '{10'b1011_00_11_00, {4'b1011, 5'b01000, 4'b0000, 4'b0001}, 2, 1'b0};
      vecs[8] = '{10'b1111_01_10_11, {4'b1111, 5'b00001, 4'b0000, 4'b0000}, 1, 1'b1};
      vecs[9] = '{10'b0101_11_00_01, {4'b0101, 5'b01000, 4'b0000, 4'b1000}, 2, 1'b0};
      for (int v = 0; v < 10; v++) begin
         applyStimulus(vecs[v].instr);
         checkOutput($sformatf("vec%0d.t1", v), 64'(trace[0]), 64'(vecs[v].t1Out));
         checkOutput($sformatf("vec%0d.latency", v), 64'(nCyc), 64'(vecs[v].latency));
         checkOutput($sformatf("vec%0d.err", v), 64'(Err), 64'(vecs[v].errAfter));
      end

      // ADD R1,R2 with R1=5, R2=3
      setRegs(10'd0, 10'd5, 10'd3, 10'd0);
      applyStimulus(10'b0010_01_10_00);
      checkOutput("add.t1", 64'(trace[0]), 64'({4'b0010, 5'b10000, 4'b0000, 4'b0100}));
      checkOutput("add.t2", 64'(trace[1]), 64'({4'b0010, 5'b01000, 4'b0000, 4'b0010}));
      checkOutput("add.t3", 64'(trace[2]), 64'({4'b0010, 5'b00101, 4'b0010, 4'b0000}));
      checkOutput("add.busyCycles", 64'(nCyc), 64'd3);
      checkOutput("add.R1", 64'(regs[1]), 64'd8);

      // LOAD R3 with external data 2A5
      extData = 10'h2A5;
      applyStimulus(10'b0000_11_10_01);
      checkOutput("load.t1", 64'(trace[0]), 64'({4'b0000, 5'b00011, 4'b1000, 4'b0000}));
      checkOutput("load.R3", 64'(regs[3]), 64'h2A5);

      // SUB R0,R0 then SHL R0
      setRegs(10'd7, 10'd1, 10'd2, 10'd3);
      applyStimulus(10'b0011_00_00_00);
      checkOutput("sub.R0", 64'(regs[0]), 64'd0);
      setRegs(10'h201, 10'd1, 10'd2, 10'd3);
      applyStimulus(10'b1001_00_00_00);
      checkOutput("shl.t1", 64'(trace[0]), 64'({4'b1001, 5'b01000, 4'b0000, 4'b0001}));
      checkOutput("shl.t2", 64'(trace[1]), 64'({4'b1001, 5'b00101, 4'b0001, 4'b0000}));
      checkOutput("shl.R0", 64'(regs[0]), 64'h002);

      // Illegal opcode with Exec held high for ten cycles
      begin
         int dc = 0;
         int bc = 0;
         logic [11:0] strobesAtDone = '0;
         INSTR = 10'b1110_00_00_00;
         Exec  = 1'b1;
         for (int c = 0; c < 10; c++) begin
            @(negedge CLKb); #1;
            if (Done) begin
               dc++;
               strobesAtDone = {Ain, Gin, Gout, ExtIn, Rin, Rout};
            end
            if (Busy) bc++;
         end
         checkOutput("illegal.doneCount", 64'(dc), 64'd1);
         checkOutput("illegal.busyCount", 64'(bc), 64'd1);
         checkOutput("illegal.strobes", 64'(strobesAtDone), 64'd0);
         checkOutput("illegal.errSet", 64'(Err), 64'd1);
         Exec = 1'b0;
         @(negedge CLKb); #1;
         checkOutput("illegal.errSticky", 64'(Err), 64'd1);
         applyStimulus(10'b0001_10_01_00);
         checkOutput("illegal.errCleared", 64'(Err), 64'd0);
      end

      // Reset pulse during T2 of an ADD
      setRegs(10'd0, 10'd5, 10'd3, 10'd0);
      INSTR = 10'b0010_01_10_00;
      Exec  = 1'b1;
      @(negedge CLKb); #1;
      Exec = 1'b0;
      @(negedge CLKb); #1;
      checkOutput("rst.inT2", 64'(Tstep), 64'd2);
      Rstb = 1'b0;
      #1;
      checkOutput("rst.outputsZero", 64'({packOut(), Busy, Err, Tstep}), 64'd0);
      @(negedge CLKb); #1;
      Rstb = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge CLKb); #1;
         checkOutput("rst.noWriteback", 64'({Gout, Rin, Tstep}), 64'd0);
      end
      checkOutput("rst.R1Unchanged", 64'(regs[1]), 64'd5);

      // Random instruction stream checked against the reference model
      setRegs(10'h011, 10'h3F0, 10'h155, 10'h2AA);
      for (int n = 0; n < 200; n++) begin
         logic [9:0] ri;
         ri      = 10'($urandom);
         extData = 10'($urandom);
         applyStimulus(ri);
         checkOutput("rand.latency", 64'(nCyc), 64'(expLatency(ri[9:6])));
         checkOutput("rand.err", 64'(Err), 64'(ri[9:8] == 2'b11));
         checkOutput("rand.regs", 64'({regs[0], regs[1], regs[2], regs[3]}),
                     64'({refRegs[0], refRegs[1], refRegs[2], refRegs[3]}));
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
